// File: rtl/regwrite_arbiter.sv
// Two-requester arbiter for the register-bank write port. The r0 requester is
// unbuffered and has priority; r1 goes through a small FIFO that starvation protects.
module regwrite_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    r0_valid,
  output logic                    r0_ready,
  input  logic [1:0]              r0_sel,
  input  logic [4:0]              r0_one,
  input  logic [4:0]              r0_two,
  input  logic [4:0]              r0_three,
  input  logic [31:0]             r0_data,
  input  logic                    r1_valid,
  output logic                    r1_ready,
  input  logic [1:0]              r1_sel,
  input  logic [4:0]              r1_one,
  input  logic [4:0]              r1_two,
  input  logic [4:0]              r1_three,
  input  logic [31:0]             r1_data,
  output logic [1:0]              wr_sel,
  output logic [31:0]             wr_one,
  output logic [31:0]             wr_two,
  output logic [31:0]             wr_three,
  output logic [31:0]             wr_data,
  output logic                    reg_write,
  output logic                    wr_src,
  output logic [$clog2(DEPTH):0]  r1_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [1:0]  sel;
    logic [4:0]  one;
    logic [4:0]  two;
    logic [4:0]  three;
    logic [31:0] data;
  } wr_req_t;

  // Same selection the downstream mux makes, so $zero writes can be suppressed here.
  function automatic logic [4:0] resolve_addr(input wr_req_t req);
    case (req.sel)
      2'b00:   resolve_addr = req.one;
      2'b01:   resolve_addr = req.two;
      2'b10:   resolve_addr = req.three;
      default: resolve_addr = 5'd31;
    endcase
  endfunction

  wr_req_t          fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;
  logic [SW-1:0]    starve_cnt_next;

  wr_req_t          r0_req;
  wr_req_t          r1_req;
  wr_req_t          win;
  logic [4:0]       win_addr;

  logic             fifo_full;
  logic             fifo_empty;
  logic             starve;
  logic             enq;
  logic             grant_r0;
  logic             grant_r1;

  assign r0_req = '{sel: r0_sel, one: r0_one, two: r0_two, three: r0_three, data: r0_data};
  assign r1_req = '{sel: r1_sel, one: r1_one, two: r1_two, three: r1_three, data: r1_data};

  // Full is taken from the registered count, so a full FIFO never passes through.
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign starve     = (starve_cnt == SW'(STARVE_MAX));

  assign r0_ready   = !starve;
  assign r1_ready   = !fifo_full;
  assign r1_count   = count;

  assign enq        = r1_valid && !fifo_full;
  assign grant_r0   = r0_valid && !starve;
  assign grant_r1   = !grant_r0 && !fifo_empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win = r0_req;
    if (grant_r1) win = fifo_mem[rd_ptr];
  end

  assign win_addr = resolve_addr(win);

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (fifo_empty || grant_r1)
      starve_cnt_next = '0;
    else if (!starve)
      starve_cnt_next = starve_cnt + SW'(1);
  end

  // NOTE: FIFO storage is not reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= r1_req;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_next;
      if (enq)      wr_ptr <= wr_ptr + AW'(1);
      if (grant_r1) rd_ptr <= rd_ptr + AW'(1);
      unique case ({enq, grant_r1})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write-port registers: a grant refreshes them even when the $zero write is suppressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_sel    <= '0;
      wr_one    <= '0;
      wr_two    <= '0;
      wr_three  <= '0;
      wr_data   <= '0;
      wr_src    <= 1'b0;
      reg_write <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      if (grant_r0 || grant_r1) begin
        wr_sel    <= win.sel;
        wr_one    <= {27'd0, win.one};
        wr_two    <= {27'd0, win.two};
        wr_three  <= {27'd0, win.three};
        wr_data   <= win.data;
        wr_src    <= grant_r1;
        reg_write <= (win_addr != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: expected writes are queued as requests
// are driven and compared whenever the DUT pulses reg_write.
module tb_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [1:0]  r0_sel, r1_sel, wr_sel;
  logic [4:0]  r0_one, r0_two, r0_three, r1_one, r1_two, r1_three;
  logic [31:0] r0_data, r1_data;
  logic [31:0] wr_one, wr_two, wr_three, wr_data;
  logic        reg_write, wr_src;
  logic [1:0]  r1_count;

  always #5 clk = ~clk;

  regwrite_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_sel(r0_sel),
    .r0_one(r0_one), .r0_two(r0_two), .r0_three(r0_three), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_sel(r1_sel),
    .r1_one(r1_one), .r1_two(r1_two), .r1_three(r1_three), .r1_data(r1_data),
    .wr_sel(wr_sel), .wr_one(wr_one), .wr_two(wr_two), .wr_three(wr_three),
    .wr_data(wr_data), .reg_write(reg_write), .wr_src(wr_src), .r1_count(r1_count)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  one;
    logic [4:0]  two;
    logic [4:0]  three;
    logic [31:0] data;
    logic        src;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] resolve(input logic [1:0] sel, input logic [4:0] a,
                                         input logic [4:0] b, input logic [4:0] c);
    case (sel)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return 5'd31;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_valid = 0; r0_sel = 0; r0_one = 0; r0_two = 0; r0_three = 0; r0_data = 0;
    r1_valid = 0; r1_sel = 0; r1_one = 0; r1_two = 0; r1_three = 0; r1_data = 0;
  endtask

  task automatic drive_r0(input logic [1:0] sel, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [31:0] d);
    r0_valid = 1; r0_sel = sel; r0_one = a; r0_two = b; r0_three = c; r0_data = d;
  endtask

  task automatic drive_r1(input logic [1:0] sel, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [31:0] d);
    r1_valid = 1; r1_sel = sel; r1_one = a; r1_two = b; r1_three = c; r1_data = d;
  endtask

  task automatic push_exp(input logic [1:0] sel, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [31:0] d, input logic src);
    exp_t e;
    e.sel = sel; e.one = a; e.two = b; e.three = c; e.data = d; e.src = src;
    exp_q.push_back(e);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && reg_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", reg_write, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_src",   wr_src,   mon_e.src);
        check("wr_sel",   wr_sel,   mon_e.sel);
        check("wr_one",   wr_one,   {27'd0, mon_e.one});
        check("wr_two",   wr_two,   {27'd0, mon_e.two});
        check("wr_three", wr_three, {27'd0, mon_e.three});
        check("wr_data",  wr_data,  mon_e.data);
        check("wr_addr",  resolve(wr_sel, wr_one[4:0], wr_two[4:0], wr_three[4:0]),
              resolve(mon_e.sel, mon_e.one, mon_e.two, mon_e.three));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 0;
    idle_inputs();

    // Reset state
    repeat (3) tick();
    reset = 1;
    @(negedge clk);
    check("rst_reg_write", reg_write, 0);
    check("rst_wr_sel",    wr_sel,    0);
    check("rst_wr_one",    wr_one,    0);
    check("rst_wr_two",    wr_two,    0);
    check("rst_wr_three",  wr_three,  0);
    check("rst_wr_data",   wr_data,   0);
    check("rst_wr_src",    wr_src,    0);
    check("rst_r1_count",  r1_count,  0);
    check("rst_r0_ready",  r0_ready,  1);
    check("rst_r1_ready",  r1_ready,  1);

    // r0 alone: one-cycle write pulse after the grant edge
    tick();
    drive_r0(2'b01, 5'd7, 5'd5, 5'd9, 32'hDEADBEEF);
    push_exp(2'b01, 5'd7, 5'd5, 5'd9, 32'hDEADBEEF, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("r0_pulse", reg_write, 1);
    tick();
    @(negedge clk);
    check("r0_pulse_width", reg_write, 0);

    // FIFO fill: r0 holds the port two cycles so r1 reaches full, third entry waits
    tick();
    drive_r0(2'b00, 5'd3, 5'd0, 5'd0, 32'h1000_0000);
    drive_r1(2'b01, 5'd0, 5'd4, 5'd0, 32'hA000_000A);
    push_exp(2'b00, 5'd3, 5'd0, 5'd0, 32'h1000_0000, 1'b0);
    tick();
    drive_r0(2'b10, 5'd0, 5'd0, 5'd6, 32'h1000_0001);
    drive_r1(2'b00, 5'd8, 5'd0, 5'd0, 32'hB000_000B);
    push_exp(2'b10, 5'd0, 5'd0, 5'd6, 32'h1000_0001, 1'b0);
    tick();
    r0_valid = 0;
    drive_r1(2'b11, 5'd0, 5'd0, 5'd0, 32'hC000_000C);
    push_exp(2'b01, 5'd0, 5'd4, 5'd0, 32'hA000_000A, 1'b1);
    @(negedge clk);
    check("fill_count_full", r1_count, 2);
    check("fill_ready_full", r1_ready, 0);
    tick();
    push_exp(2'b00, 5'd8, 5'd0, 5'd0, 32'hB000_000B, 1'b1);
    @(negedge clk);
    check("fill_count_after_deq", r1_count, 1);
    check("fill_ready_after_deq", r1_ready, 1);
    tick();
    r1_valid = 0;
    push_exp(2'b11, 5'd0, 5'd0, 5'd0, 32'hC000_000C, 1'b1);
    @(negedge clk);
    check("fill_count_third", r1_count, 1);
    tick();
    @(negedge clk);
    check("fill_count_empty", r1_count, 0);
    tick();
    check("fill_drained", exp_q.size(), 0);

    // Starvation: r0 continuously valid, one r1 entry waiting
    drive_r0(2'b01, 5'd0, 5'd10, 5'd0, 32'h5000_0000);
    drive_r1(2'b01, 5'd0, 5'd20, 5'd0, 32'hD000_000D);
    push_exp(2'b01, 5'd0, 5'd10, 5'd0, 32'h5000_0000, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      r1_valid = 0;
      drive_r0(2'b01, 5'd0, 5'd10, 5'd0, 32'h5000_0000 + 32'(i));
      push_exp(2'b01, 5'd0, 5'd10, 5'd0, 32'h5000_0000 + 32'(i), 1'b0);
      @(negedge clk);
      check("starve_r0_ready", r0_ready, 1);
    end
    tick();
    drive_r0(2'b01, 5'd0, 5'd10, 5'd0, 32'h5000_0005);
    drive_r1(2'b10, 5'd0, 5'd0, 5'd21, 32'hE000_000E);
    push_exp(2'b01, 5'd0, 5'd20, 5'd0, 32'hD000_000D, 1'b1);
    @(negedge clk);
    check("starve_stall", r0_ready, 0);
    check("starve_r1_ready", r1_ready, 1);
    tick();
    r1_valid = 0;
    push_exp(2'b01, 5'd0, 5'd10, 5'd0, 32'h5000_0005, 1'b0);
    @(negedge clk);
    check("starve_cleared", r0_ready, 1);
    check("starve_enq_accepted", r1_count, 1);
    tick();
    r0_valid = 0;
    push_exp(2'b10, 5'd0, 5'd0, 5'd21, 32'hE000_000E, 1'b1);
    tick();
    @(negedge clk);
    check("starve_count_empty", r1_count, 0);
    tick();
    check("starve_drained", exp_q.size(), 0);

    // $zero suppression on both requesters, then a $ra write
    drive_r1(2'b00, 5'd0, 5'd3, 5'd4, 32'h0BAD_0000);
    tick();
    r1_valid = 0;
    tick();
    @(negedge clk);
    check("zero_r1_suppressed", reg_write, 0);
    check("zero_r1_src", wr_src, 1);
    check("zero_r1_sel", wr_sel, 0);
    check("zero_r1_two", wr_two, 3);
    check("zero_r1_consumed", r1_count, 0);
    tick();
    drive_r0(2'b01, 5'd1, 5'd0, 5'd2, 32'h0BAD_0001);
    tick();
    idle_inputs();
    @(negedge clk);
    check("zero_r0_suppressed", reg_write, 0);
    check("zero_r0_src", wr_src, 0);
    check("zero_r0_sel", wr_sel, 1);
    tick();
    drive_r0(2'b11, 5'd1, 5'd2, 5'd3, 32'hCAFE_F00D);
    push_exp(2'b11, 5'd1, 5'd2, 5'd3, 32'hCAFE_F00D, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("ra_write", reg_write, 1);
    tick();
    check("zero_drained", exp_q.size(), 0);

    // Asynchronous reset with FIFO full and a write pulse in flight
    drive_r0(2'b01, 5'd0, 5'd12, 5'd0, 32'h7000_0000);
    drive_r1(2'b01, 5'd0, 5'd13, 5'd0, 32'h8000_0000);
    push_exp(2'b01, 5'd0, 5'd12, 5'd0, 32'h7000_0000, 1'b0);
    tick();
    drive_r0(2'b01, 5'd0, 5'd14, 5'd0, 32'h7000_0001);
    drive_r1(2'b01, 5'd0, 5'd15, 5'd0, 32'h8000_0001);
    push_exp(2'b01, 5'd0, 5'd14, 5'd0, 32'h7000_0001, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("arst_pre_count", r1_count, 2);
    check("arst_pre_pulse", reg_write, 1);
    #1;
    reset = 0;
    #1;
    check("arst_pulse_drop", reg_write, 0);
    check("arst_count", r1_count, 0);
    check("arst_r1_ready", r1_ready, 1);
    check("arst_r0_ready", r0_ready, 1);
    exp_q.delete();
    repeat (2) tick();
    reset = 1;
    repeat (6) tick();
    @(negedge clk);
    check("arst_post_count", r1_count, 0);
    check("arst_post_write", reg_write, 0);
    check("arst_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
